// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domain resets, then release stage 0..N-1 in order.
// Optional macro RESET_SEQ_STAGE_ACK_EN gates each release on the previous stage's ack or a timeout.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_DELAY = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SW_REQ,
`ifdef RESET_SEQ_STAGE_ACK_EN
    input  logic [NUM_STAGES-1:0] STAGE_ACK,
    output logic                  ACK_ERR,
`endif
    output logic [NUM_STAGES-1:0] OUT_RST,
    output logic                  SEQ_DONE,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_RELEASE  = 2'd1,
        S_DONE     = 2'd2
`ifdef RESET_SEQ_STAGE_ACK_EN
        , S_WAIT_ACK = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   out_rst_q, out_rst_d;
    logic                    seq_done_q, seq_done_d;
`ifdef RESET_SEQ_STAGE_ACK_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic                    ack_err_q, ack_err_d;
    logic                    ack_sel;
    logic                    ack_ok;
    logic [IDX_W-1:0]        idx_nxt;
`endif

    // Index-safe bit clear: idx may address past the vector for non power-of-two stage counts.
    function automatic logic [NUM_STAGES-1:0] clr_bit(input logic [NUM_STAGES-1:0] v,
                                                      input logic [IDX_W-1:0] k);
        logic [NUM_STAGES-1:0] r;
        r = v;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == k) r[i] = 1'b0;
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_rst_q  <= '1;
            seq_done_q <= 1'b0;
`ifdef RESET_SEQ_STAGE_ACK_EN
            ack_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            out_rst_q  <= out_rst_d;
            seq_done_q <= seq_done_d;
`ifdef RESET_SEQ_STAGE_ACK_EN
            ack_err_q  <= ack_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        out_rst_d  = out_rst_q;
        seq_done_d = seq_done_q;
`ifdef RESET_SEQ_STAGE_ACK_EN
        ack_err_d  = ack_err_q;
        ack_sel    = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == idx_q) ack_sel = STAGE_ACK[i];
        end
        ack_ok  = (cnt_q >= DELAY_LAST) && ack_sel;
        idx_nxt = idx_q + 1'b1;
`endif
        // A software request restarts the sequence from any state and beats a pending release.
        if (SW_REQ) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            out_rst_d  = '1;
            seq_done_d = 1'b0;
`ifdef RESET_SEQ_STAGE_ACK_EN
            ack_err_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        out_rst_d = clr_bit(out_rst_q, '0);
                        cnt_d     = '0;
`ifdef RESET_SEQ_STAGE_ACK_EN
                        idx_d     = '0;
                        state_d   = S_WAIT_ACK;
`else
                        idx_d     = IDX_W'(1);
                        if (NUM_STAGES > 1) begin
                            state_d = S_RELEASE;
                        end else begin
                            state_d    = S_DONE;
                            seq_done_d = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == DELAY_LAST) begin
                        out_rst_d = clr_bit(out_rst_q, idx_q);
                        cnt_d     = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d    = S_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef RESET_SEQ_STAGE_ACK_EN
                // idx is the stage just released; the next one goes once it acks or times out.
                S_WAIT_ACK: begin
                    if (ack_ok || cnt_q == TMO_LAST) begin
                        if (!ack_ok) ack_err_d = 1'b1;
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d    = S_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            idx_d     = idx_nxt;
                            out_rst_d = clr_bit(out_rst_q, idx_nxt);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    out_rst_d  = '0;
                    seq_done_d = 1'b1;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_comb begin
        OUT_RST   = out_rst_q;
        SEQ_DONE  = seq_done_q;
        state_dbg = state_q;
`ifdef RESET_SEQ_STAGE_ACK_EN
        ACK_ERR   = ack_err_q;
`endif
    end

endmodule
